// File: rtl/pkt_slot_seq_pkg.sv
// Shared types and the packet-type occupancy table for the baseband slot sequencer.
package bb_slot_pkg;

  typedef enum logic [1:0] {StIdle, StTx, StRx} slot_st_e;

  typedef enum logic [3:0] {
    PkNull = 4'h0, PkPoll = 4'h1, PkFhs = 4'h2, PkDm1 = 4'h3,
    PkDh1  = 4'h4, PkHv1  = 4'h5, PkHv2 = 4'h6, PkHv3 = 4'h7,
    PkDv   = 4'h8, PkAux1 = 4'h9, PkDm3 = 4'ha, PkDh3 = 4'hb,
    PkEv4  = 4'hc, PkEv5  = 4'hd, PkDm5 = 4'he, PkDh5 = 4'hf
  } pk_type_e;

  // Raw occupancy before any MAX_SLOTS clamp.
  function automatic int unsigned slots_of_type(logic [3:0] pk_type);
    int unsigned n;
    case (pk_type)
      PkDm3, PkDh3, PkEv4, PkEv5: n = 3;
      PkDm5, PkDh5:               n = 5;
      default:                    n = 1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pkt_slot_seq_if.sv
// Control/status bundle between the link controller and the slot sequencer.
interface pkt_slot_seq_if #(
  parameter int unsigned CNT_W = 3
) ();
  logic             ms_tslot_p;
  logic             tx_start;
  logic             rx_start;
  logic [3:0]       tx_pk_type;
  logic             rx_hdr_valid;
  logic             rx_hdr_err;
  logic [3:0]       rx_pk_type;
  logic             abort;
  logic             tx_active;
  logic             rx_active;
  logic [CNT_W-1:0] tx_slot_idx;
  logic [CNT_W-1:0] rx_slot_idx;
  logic [CNT_W-1:0] tx_occ_slots;
  logic [CNT_W-1:0] rx_occ_slots;
  logic             txextendslot;
  logic             rxextendslot;
  logic             conns_rx1stslot;
  logic             ms_TXslot_endp;
  logic             ms_RXslot_endp;
  logic             slots_err;
  logic             start_drop;

  modport master (
    output ms_tslot_p, tx_start, rx_start, tx_pk_type, rx_hdr_valid, rx_hdr_err, rx_pk_type,
           abort,
    input  tx_active, rx_active, tx_slot_idx, rx_slot_idx, tx_occ_slots, rx_occ_slots,
           txextendslot, rxextendslot, conns_rx1stslot, ms_TXslot_endp, ms_RXslot_endp,
           slots_err, start_drop
  );

  modport slave (
    input  ms_tslot_p, tx_start, rx_start, tx_pk_type, rx_hdr_valid, rx_hdr_err, rx_pk_type,
           abort,
    output tx_active, rx_active, tx_slot_idx, rx_slot_idx, tx_occ_slots, rx_occ_slots,
           txextendslot, rxextendslot, conns_rx1stslot, ms_TXslot_endp, ms_RXslot_endp,
           slots_err, start_drop
  );
endinterface

// File: rtl/pkt_slot_seq_occ_decode.sv
// Packet type to slot occupancy, clamped to MAX_SLOTS with an overflow flag.
module slot_occ_decode
  import bb_slot_pkg::*;
#(
  parameter int unsigned MAX_SLOTS = 5,
  parameter int unsigned CNT_W     = 3
) (
  input  logic [3:0]       pk_type_i,
  output logic [CNT_W-1:0] occ_o,
  output logic             clamped_o
);
  int unsigned raw;

  always_comb begin
    raw       = slots_of_type(pk_type_i);
    clamped_o = raw > MAX_SLOTS;
    occ_o     = clamped_o ? CNT_W'(MAX_SLOTS) : CNT_W'(raw);
  end
endmodule

// File: rtl/pkt_slot_seq.sv
// TX/RX multi-slot sequencer: tracks slot occupancy per direction and flags slot boundaries.
module pkt_slot_seq
  import bb_slot_pkg::*;
#(
  parameter int unsigned MAX_SLOTS = 5,
  parameter int unsigned CNT_W     = 3
) (
  input logic           clk_6M,
  input logic           rst,
  pkt_slot_seq_if.slave bus
);
  slot_st_e         st_q, st_d;
  logic [CNT_W-1:0] tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic [CNT_W-1:0] tx_occ_q, tx_occ_d, rx_occ_q, rx_occ_d;
  logic [CNT_W-1:0] tx_dec_occ, rx_dec_occ;
  logic             tx_dec_clamp, rx_dec_clamp;
  logic             tx_last, rx_last, bnd, tx_load, rx_hdr_load, drop;

  slot_occ_decode #(.MAX_SLOTS(MAX_SLOTS), .CNT_W(CNT_W)) u_tx_dec (
    .pk_type_i (bus.tx_pk_type),
    .occ_o     (tx_dec_occ),
    .clamped_o (tx_dec_clamp)
  );

  slot_occ_decode #(.MAX_SLOTS(MAX_SLOTS), .CNT_W(CNT_W)) u_rx_dec (
    .pk_type_i (bus.rx_pk_type),
    .occ_o     (rx_dec_occ),
    .clamped_o (rx_dec_clamp)
  );

  assign tx_last = tx_idx_q == tx_occ_q;
  assign rx_last = rx_idx_q >= rx_occ_q;
  assign bnd     = bus.ms_tslot_p & ~bus.abort;

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      st_q     <= StIdle;
      tx_idx_q <= '0;
      rx_idx_q <= '0;
      tx_occ_q <= CNT_W'(1);
      rx_occ_q <= CNT_W'(1);
    end else begin
      st_q     <= st_d;
      tx_idx_q <= tx_idx_d;
      rx_idx_q <= rx_idx_d;
      tx_occ_q <= tx_occ_d;
      rx_occ_q <= rx_occ_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    tx_idx_d    = tx_idx_q;
    rx_idx_d    = rx_idx_q;
    tx_occ_d    = tx_occ_q;
    rx_occ_d    = rx_occ_q;
    tx_load     = 1'b0;
    rx_hdr_load = 1'b0;
    if (bus.abort) begin
      st_d     = StIdle;
      tx_idx_d = '0;
      rx_idx_d = '0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (bus.ms_tslot_p) begin
            if (bus.tx_start) begin
              tx_load = 1'b1;
            end else if (bus.rx_start) begin
              st_d     = StRx;
              rx_idx_d = CNT_W'(1);
              rx_occ_d = CNT_W'(1);
            end
          end
        end
        StTx: begin
          if (bus.ms_tslot_p) begin
            if (tx_last) begin
              st_d     = StRx;
              tx_idx_d = '0;
              rx_idx_d = CNT_W'(1);
              rx_occ_d = CNT_W'(1);
            end else begin
              tx_idx_d = tx_idx_q + CNT_W'(1);
            end
          end
        end
        StRx: begin
          // Only a clean header in the first RX slot may extend the window.
          if (bus.rx_hdr_valid && !bus.rx_hdr_err && rx_idx_q == CNT_W'(1)) begin
            rx_hdr_load = 1'b1;
            rx_occ_d    = rx_dec_occ;
          end
          if (bus.ms_tslot_p) begin
            if (rx_last) begin
              rx_idx_d = '0;
              if (bus.tx_start) tx_load = 1'b1;
              else              st_d    = StIdle;
            end else begin
              rx_idx_d = rx_idx_q + CNT_W'(1);
            end
          end
        end
        default: st_d = StIdle;
      endcase
      if (tx_load) begin
        st_d     = StTx;
        tx_idx_d = CNT_W'(1);
        tx_occ_d = tx_dec_occ;
      end
    end
  end

  always_comb begin
    drop = 1'b0;
    if (bnd) begin
      unique case (st_q)
        StIdle:  drop = bus.tx_start & bus.rx_start;
        StTx:    drop = bus.tx_start | bus.rx_start;
        StRx:    drop = rx_last ? bus.rx_start : (bus.tx_start | bus.rx_start);
        default: drop = 1'b0;
      endcase
    end
    bus.tx_active       = st_q == StTx;
    bus.rx_active       = st_q == StRx;
    bus.tx_slot_idx     = tx_idx_q;
    bus.rx_slot_idx     = rx_idx_q;
    bus.tx_occ_slots    = tx_occ_q;
    bus.rx_occ_slots    = rx_occ_q;
    bus.txextendslot    = (st_q == StTx) && (tx_idx_q >= CNT_W'(2));
    bus.rxextendslot    = (st_q == StRx) && (rx_idx_q >= CNT_W'(2));
    bus.conns_rx1stslot = (st_q == StRx) && (rx_idx_q == CNT_W'(1));
    bus.ms_TXslot_endp  = ~rst & bnd & (st_q == StTx) & tx_last;
    bus.ms_RXslot_endp  = ~rst & bnd & (st_q == StRx) & rx_last;
    bus.slots_err       = ~rst & ((tx_load & tx_dec_clamp) | (rx_hdr_load & rx_dec_clamp));
    bus.start_drop      = ~rst & drop;
  end
endmodule

// File: tb/tb_pkt_slot_seq.sv
// Randomised bench: two sequencers (MAX_SLOTS 5 and 3) against a slot-schedule reference model.
module tb_pkt_slot_seq;
  localparam int unsigned CNT_W = 3;

  logic clk_6M = 1'b0;
  always #5 clk_6M = ~clk_6M;

  logic       rst, tslot, txs, rxs, hv, he, ab;
  logic [3:0] txpk, rxpk;

  pkt_slot_seq_if #(.CNT_W(CNT_W)) if5 ();
  pkt_slot_seq_if #(.CNT_W(CNT_W)) if3 ();

  assign if5.ms_tslot_p = tslot;  assign if3.ms_tslot_p = tslot;
  assign if5.tx_start = txs;      assign if3.tx_start = txs;
  assign if5.rx_start = rxs;      assign if3.rx_start = rxs;
  assign if5.tx_pk_type = txpk;   assign if3.tx_pk_type = txpk;
  assign if5.rx_hdr_valid = hv;   assign if3.rx_hdr_valid = hv;
  assign if5.rx_hdr_err = he;     assign if3.rx_hdr_err = he;
  assign if5.rx_pk_type = rxpk;   assign if3.rx_pk_type = rxpk;
  assign if5.abort = ab;          assign if3.abort = ab;

  pkt_slot_seq #(.MAX_SLOTS(5), .CNT_W(CNT_W)) dut5 (.clk_6M(clk_6M), .rst(rst), .bus(if5));
  pkt_slot_seq #(.MAX_SLOTS(3), .CNT_W(CNT_W)) dut3 (.clk_6M(clk_6M), .rst(rst), .bus(if3));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input int m, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s dut%0d at %0t: got %0d expected %0d", tag, (m == 0) ? 5 : 3, $time,
                  got, exp);
  endtask

  // Reference model: the exchange is a list of upcoming slots, each coded dir*8+idx
  // (dir 1 = TX, 2 = RX); cur is the slot now in progress, 0 when idle.
  int maxs [2] = '{5, 3};
  int cur [2];
  int sched [2][16];
  int hd [2];
  int tl [2];
  int txocc [2];
  int rxocc [2];
  int e_ta [2], e_ra [2], e_ti [2], e_ri [2], e_to [2], e_ro [2], e_txe [2], e_rxe [2];
  int e_r1 [2], e_te [2], e_re [2], e_se [2], e_sd [2];

  function automatic int raw_slots(input logic [3:0] pk);
    if (pk >= 4'ha && pk <= 4'hd) return 3;
    if (pk >= 4'he) return 5;
    return 1;
  endfunction

  task automatic push(input int m, input int v);
    sched[m][tl[m]] = v;
    tl[m]++;
  endtask

  task automatic model_eval(input int m);
    int  d, i, n, occ;
    bit  more, go_tx, go_rx;
    if (rst) begin
      cur[m] = 0; hd[m] = 0; tl[m] = 0; txocc[m] = 1; rxocc[m] = 1;
    end
    d = cur[m] / 8;
    i = cur[m] % 8;
    e_ta[m] = int'(d == 1);  e_ra[m] = int'(d == 2);
    e_ti[m] = (d == 1) ? i : 0;  e_ri[m] = (d == 2) ? i : 0;
    e_to[m] = txocc[m];  e_ro[m] = rxocc[m];
    e_txe[m] = int'(d == 1 && i >= 2);  e_rxe[m] = int'(d == 2 && i >= 2);
    e_r1[m] = int'(d == 2 && i == 1);
    e_te[m] = 0; e_re[m] = 0; e_se[m] = 0; e_sd[m] = 0;
    if (rst) return;
    if (ab) begin
      cur[m] = 0; hd[m] = 0; tl[m] = 0;
      return;
    end
    more = (hd[m] != tl[m]) && (sched[m][hd[m]] / 8 == d);
    if (tslot) begin
      e_te[m] = int'(d == 1 && !more);
      e_re[m] = int'(d == 2 && !more);
    end
    if (hv && !he && d == 2 && i == 1) begin
      n = raw_slots(rxpk);
      occ = (n > maxs[m]) ? maxs[m] : n;
      e_se[m] = int'(n > maxs[m]);
      rxocc[m] = occ;
      tl[m] = hd[m];
      for (int k = 2; k <= occ; k++) push(m, 16 + k);
    end
    if (tslot) begin
      go_tx = 1'b0; go_rx = 1'b0;
      if (d == 0) begin
        go_tx = txs; go_rx = !txs && rxs; e_sd[m] = int'(txs && rxs);
      end else if (d == 2 && hd[m] == tl[m]) begin
        go_tx = txs; e_sd[m] = int'(rxs);
      end else begin
        e_sd[m] = int'(txs || rxs);
      end
      if (go_tx) begin
        n = raw_slots(txpk);
        occ = (n > maxs[m]) ? maxs[m] : n;
        e_se[m] = e_se[m] | int'(n > maxs[m]);
        txocc[m] = occ;
        hd[m] = 0; tl[m] = 0;
        for (int k = 1; k <= occ; k++) push(m, 8 + k);
        push(m, 17);
      end else if (go_rx) begin
        hd[m] = 0; tl[m] = 0;
        push(m, 17);
      end
      if (hd[m] != tl[m]) begin
        cur[m] = sched[m][hd[m]];
        hd[m]++;
        if (cur[m] == 17) rxocc[m] = 1;
      end else begin
        cur[m] = 0;
      end
    end
  endtask

  task automatic cmp(input int m, input logic ta, ra, input logic [2:0] ti, ri, to, ro,
                     input logic txe, rxe, r1, te, re, se, sd);
    check_eq("tx_active", m, int'(ta), e_ta[m]);
    check_eq("rx_active", m, int'(ra), e_ra[m]);
    check_eq("tx_slot_idx", m, int'(ti), e_ti[m]);
    check_eq("rx_slot_idx", m, int'(ri), e_ri[m]);
    check_eq("tx_occ_slots", m, int'(to), e_to[m]);
    check_eq("rx_occ_slots", m, int'(ro), e_ro[m]);
    check_eq("txextendslot", m, int'(txe), e_txe[m]);
    check_eq("rxextendslot", m, int'(rxe), e_rxe[m]);
    check_eq("conns_rx1stslot", m, int'(r1), e_r1[m]);
    check_eq("ms_TXslot_endp", m, int'(te), e_te[m]);
    check_eq("ms_RXslot_endp", m, int'(re), e_re[m]);
    check_eq("slots_err", m, int'(se), e_se[m]);
    check_eq("start_drop", m, int'(sd), e_sd[m]);
  endtask

  task automatic tick(input bit r, input bit ts, input bit tx, input bit rx, input logic [3:0] tp,
                      input bit h, input bit e, input logic [3:0] rp, input bit a, input bit chk);
    @(negedge clk_6M);
    rst = r; tslot = ts; txs = tx; rxs = rx; txpk = tp; hv = h; he = e; rxpk = rp; ab = a;
    #1;
    model_eval(0);
    model_eval(1);
    if (chk) begin
      cmp(0, if5.tx_active, if5.rx_active, if5.tx_slot_idx, if5.rx_slot_idx, if5.tx_occ_slots,
          if5.rx_occ_slots, if5.txextendslot, if5.rxextendslot, if5.conns_rx1stslot,
          if5.ms_TXslot_endp, if5.ms_RXslot_endp, if5.slots_err, if5.start_drop);
      cmp(1, if3.tx_active, if3.rx_active, if3.tx_slot_idx, if3.rx_slot_idx, if3.tx_occ_slots,
          if3.rx_occ_slots, if3.txextendslot, if3.rxextendslot, if3.conns_rx1stslot,
          if3.ms_TXslot_endp, if3.ms_RXslot_endp, if3.slots_err, if3.start_drop);
    end
  endtask

  // One 4-cycle slot: boundary in cycle 0, optional header in cycle 2, optional abort.
  task automatic slot(input bit tx, input bit rx, input logic [3:0] tp, input bit h, input bit e,
                      input logic [3:0] rp, input int ab_at);
    for (int c = 0; c < 4; c++)
      tick(1'b0, c == 0, c == 0 && tx, c == 0 && rx, tp, c == 2 && h, c == 2 && e, rp,
           c == ab_at, 1'b1);
  endtask

  initial begin
    rst = 1'b1; tslot = 0; txs = 0; rxs = 0; txpk = 0; hv = 0; he = 0; rxpk = 0; ab = 0;
    tick(1, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
    tick(1, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 1);

    // DM1 single-slot TX then one RX slot.
    slot(1, 0, 4'h3, 0, 0, 4'h0, -1);
    slot(0, 0, 4'h0, 0, 0, 4'h0, -1);
    check_eq("dm1_rx_first", 0, int'(if5.conns_rx1stslot), 1);
    slot(0, 0, 4'h0, 0, 0, 4'h0, -1);
    check_eq("dm1_idle", 0, int'(if5.rx_active | if5.tx_active), 0);

    // DH5 spans five TX slots; clamped to three on the MAX_SLOTS=3 instance.
    slot(1, 0, 4'hf, 0, 0, 4'h0, -1);
    check_eq("dh5_clamp_occ", 1, int'(if3.tx_occ_slots), 3);
    slot(0, 0, 4'h0, 0, 0, 4'h0, -1);
    slot(0, 0, 4'h0, 0, 0, 4'h0, -1);
    check_eq("dh5_idx3", 0, int'(if5.tx_slot_idx), 3);
    check_eq("dh5_ext", 0, int'(if5.txextendslot), 1);
    for (int s = 0; s < 4; s++) slot(0, 0, 4'h0, 0, 0, 4'h0, -1);

    // Received DH3 header extends RX to three slots; a bad HEC does not.
    slot(1, 0, 4'h3, 0, 0, 4'h0, -1);
    slot(0, 0, 4'h0, 1, 0, 4'hb, -1);
    check_eq("dh3_rx_occ", 0, int'(if5.rx_occ_slots), 3);
    for (int s = 0; s < 3; s++) slot(0, 0, 4'h0, 0, 0, 4'h0, -1);
    slot(1, 0, 4'h3, 0, 0, 4'h0, -1);
    slot(0, 0, 4'h0, 1, 1, 4'hb, -1);
    check_eq("hec_rx_occ", 0, int'(if5.rx_occ_slots), 1);
    slot(0, 0, 4'h0, 0, 0, 4'h0, -1);

    // Abort mid-DM5, and abort on an ending boundary.
    slot(1, 0, 4'he, 0, 0, 4'h0, -1);
    slot(0, 0, 4'h0, 0, 0, 4'h0, 1);
    check_eq("abort_idle", 0, int'(if5.tx_active), 0);
    check_eq("abort_idx", 0, int'(if5.tx_slot_idx), 0);
    slot(1, 0, 4'h4, 0, 0, 4'h0, -1);
    slot(0, 0, 4'h0, 0, 0, 4'h0, 0);
    check_eq("abort_bnd_idle", 0, int'(if5.rx_active), 0);

    // Slave RX start, then back-to-back TX from the final RX boundary.
    slot(0, 1, 4'h0, 0, 0, 4'h0, -1);
    check_eq("rx_start_idx", 0, int'(if5.rx_slot_idx), 1);
    slot(1, 0, 4'h3, 0, 0, 4'h0, -1);
    check_eq("b2b_tx_idx", 0, int'(if5.tx_slot_idx), 1);
    check_eq("b2b_rx_idx", 0, int'(if5.rx_slot_idx), 0);
    slot(0, 0, 4'h0, 0, 0, 4'h0, -1);
    slot(0, 0, 4'h0, 0, 0, 4'h0, -1);

    for (int s = 0; s < 600; s++)
      slot($urandom_range(2) == 0, $urandom_range(2) == 0, 4'($urandom_range(15)),
           $urandom_range(1) == 1, $urandom_range(3) == 0, 4'($urandom_range(15)),
           ($urandom_range(19) == 0) ? int'($urandom_range(3)) : -1);

    tick(1, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
    tick(1, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 1);
    tick(0, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
